jtdd_gfxrom_arb: RTL and testbench
==================================

// Module: jtdd_gfxrom_arb
// PURPOSE
//  Shares one 8-bit graphics ROM port (SDRAM bank) among three tile fetchers: char, scroll and object.
//  Each client presents an address and reads back data with an ok flag. The char client is the
//  timing-critical one, since it changes address every two pixels. The arbiter sits between the
//  video layers and the SDRAM controller.
// PARAMETERS
//  CW      18       client address width (bits)
//  AW      20       downstream ROM address width; must satisfy AW >= CW
//  CHAR_OFF 20'h0   offset added to char_addr
//  SCR_OFF 20'h10000 offset added to scr_addr
//  OBJ_OFF 20'h40000 offset added to obj_addr
// PORTS
//  clk       in   1   system clock
//  rst_n     in   1   asynchronous reset, active low
//  char_cs   in   1   char client requesting
//  char_addr in   CW  char ROM address
//  char_data out  8   char data
//  char_ok   out  1   char_data valid for the current char_addr
//  scr_cs/scr_addr/scr_data/scr_ok      same as char_* for scroll
//  obj_cs/obj_addr/obj_data/obj_ok      same as char_* for objects
//  rom_req   out  1   request to SDRAM; held high until rom_ack
//  rom_addr  out  AW  {offset + client address}, stable while rom_req is high
//  rom_ack   in   1   request accepted (1-cycle pulse)
//  rom_dst   in   1   rom_data valid (1-cycle pulse, arrives after rom_ack)
//  rom_data  in   8   ROM read data
//  stall_cnt out  48  {obj,scr,char} 16-bit miss counters; present only with JTDD_ARB_STATS_EN
// BEHAVIOUR
//  - Per client, a 1-entry tag cache holds {valid, tag[CW-1:0], data[7:0]}.
//  - x_ok = x_cs & valid & (tag == x_addr). The compare is combinational, so ok drops in the same
//    cycle that the address changes. x_data = cached data.
//  - Miss: x_cs & !x_ok.
//  - FSM states:
//    IDLE: pick a missing client.
//      - Char has fixed top priority.
//      - Scroll and object alternate round-robin through a 1-bit last-grant register.
//      - On grant: latch the client id and client address, drive rom_addr, assert rom_req, go to REQ.
//    REQ: hold rom_req and rom_addr until rom_ack. On rom_ack, drop rom_req the next cycle and go
//      to WAIT.
//    WAIT: on rom_dst, write {1, latched addr, rom_data} into the granted client's cache, set its
//      ok on the following cycle if the address still matches, and go to IDLE.
//  - rom_ack and rom_dst in the same cycle: treat as REQ->WAIT->fill in that cycle and go to IDLE.
//  - Client address changes in flight: the fill still lands with the latched tag, so ok stays low
//    and a new miss is serviced afterwards. No abort.
//  - cs drops in flight: the fill completes; ok is gated low by cs.
//  - Minimum miss latency: 1 cycle (IDLE) + ack wait + dst wait + 1 cycle.
//  - Back-to-back misses re-arbitrate in IDLE with no extra bubble.
//  - Address arithmetic: rom_addr = OFF + zero-extended client address, truncated to AW bits.
//    Wrap-around is silent.
//  - Reset (asynchronous, any state, mid-transaction included): state=IDLE, rom_req=0,
//    rom_addr=0, all valid=0, all x_data=0, all x_ok=0, RR pointer=scroll, stall counters=0.
//    A rom_dst that arrives after reset is ignored.
// CONFIGURATION
//  JTDD_ARB_STATS_EN defined: the stall_cnt port exists. Each 16-bit counter increments on every
//    cycle its client has a miss, and saturates at 16'hFFFF.
//  JTDD_ARB_STATS_EN undefined: no stall_cnt port and no counter logic. All other behaviour is
//    identical.
// STRUCTURE
//  Package jtdd_gfxrom_pkg:
//    - client id enum: CL_CHAR=0, CL_SCR=1, CL_OBJ=2
//    - FSM state enum: IDLE, REQ, WAIT
//    - localparam NCL=3
//  Sub-module jtdd_gfxrom_slot: the per-client tag cache and ok compare, instantiated 3 times.
//  The top level holds the FSM, the arbitration and the output mux.
// TESTING
//  1. Reset, then char_cs=1, char_addr=18'h00123; SDRAM model ack after 2 cycles, dst after 4
//     with 8'hA5 -> rom_addr=20'h00123, then char_ok=1 and char_data=8'hA5. Change addr to 18'h00124
//     -> char_ok=0 in the same cycle.
//  2. Scroll and object miss together, char idle -> the first grant goes to scroll
//     (rom_addr=SCR_OFF+addr), the second to object. A repeated tie grants object, then scroll.
//  3. Char, scroll and object all miss -> char is served first. The next tie is scroll versus object
//     per the RR pointer, and char is never starved.
//  4. Change char_addr while in WAIT, then send dst -> char_ok stays 0 and a new rom_req with the
//     new address follows the fill.
//  5. Assert rst_n=0 in REQ with rom_req high -> rom_req=0 asynchronously and all ok=0. A late dst
//     after release changes no cache.
//  6. With JTDD_ARB_STATS_EN: hold a scroll miss for 70000 cycles (no ack) -> stall_cnt[31:16]
//     reads 16'hFFFF.

Source files
------------

// File: rtl/jtdd_gfxrom_pkg.sv
// Shared types for the graphics ROM arbiter: client ids, FSM states and the
// fixed-priority / round-robin pick function.
package jtdd_gfxrom_pkg;
  localparam int NCL = 3;

  typedef enum logic [1:0] {CL_CHAR = 2'd0, CL_SCR = 2'd1, CL_OBJ = 2'd2} client_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

  // Char always wins; scroll/object ties go to whoever was not granted last.
  function automatic client_e arb_pick(input logic [NCL-1:0] miss, input logic rr_obj);
    if (miss[CL_CHAR])                 return CL_CHAR;
    if (miss[CL_SCR] && miss[CL_OBJ])  return rr_obj ? CL_OBJ : CL_SCR;
    if (miss[CL_OBJ])                  return CL_OBJ;
    return CL_SCR;
  endfunction
endpackage

// File: rtl/jtdd_gfxrom_slot.sv
// One-entry tag cache for a single ROM client. ok is a pure combinational
// compare so it falls in the same cycle the client moves its address.
module jtdd_gfxrom_slot #(
  parameter int CW = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [CW-1:0] addr,
  input  logic          fill,
  input  logic [CW-1:0] fill_tag,
  input  logic [7:0]    fill_data,
  output logic [7:0]    data,
  output logic          ok,
  output logic          miss
);
  logic          vld;
  logic [CW-1:0] tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      tag  <= '0;
      data <= '0;
    end else if (fill) begin
      vld  <= 1'b1;
      tag  <= fill_tag;
      data <= fill_data;
    end
  end

  assign ok   = cs & vld & (tag == addr);
  assign miss = cs & ~ok;
endmodule

// File: rtl/jtdd_gfxrom_arb.sv
// Three-client arbiter in front of one 8-bit SDRAM ROM bank (char/scroll/obj).
// Define JTDD_ARB_STATS_EN to add the saturating per-client stall_cnt counters.
module jtdd_gfxrom_arb
  import jtdd_gfxrom_pkg::*;
#(
  parameter int          CW       = 18,
  parameter int          AW       = 20,
  parameter logic [AW-1:0] CHAR_OFF = 20'h0,
  parameter logic [AW-1:0] SCR_OFF  = 20'h10000,
  parameter logic [AW-1:0] OBJ_OFF  = 20'h40000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          char_cs,
  input  logic [CW-1:0] char_addr,
  output logic [7:0]    char_data,
  output logic          char_ok,
  input  logic          scr_cs,
  input  logic [CW-1:0] scr_addr,
  output logic [7:0]    scr_data,
  output logic          scr_ok,
  input  logic          obj_cs,
  input  logic [CW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          obj_ok,
  output logic          rom_req,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_ack,
  input  logic          rom_dst,
  input  logic [7:0]    rom_data
`ifdef JTDD_ARB_STATS_EN
  ,
  output logic [47:0]   stall_cnt
`endif
);
  logic [NCL-1:0]         cs, miss, ok, fill;
  logic [NCL-1:0][CW-1:0] addr;
  logic [NCL-1:0][7:0]    data;
  logic [NCL-1:0][AW-1:0] off;

  assign cs   = {obj_cs, scr_cs, char_cs};
  assign addr = {obj_addr, scr_addr, char_addr};
  assign off  = {OBJ_OFF, SCR_OFF, CHAR_OFF};

  state_e        state, state_nx;
  client_e       gnt, gnt_nx, pick;
  logic          rr_obj, rr_nx;
  logic [CW-1:0] lat_addr, lat_nx;
  logic          req_nx;
  logic [AW-1:0] addr_nx;

  generate
    for (genvar i = 0; i < NCL; i++) begin : g_slot
      jtdd_gfxrom_slot #(.CW(CW)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs[i]),
        .addr      (addr[i]),
        .fill      (fill[i]),
        .fill_tag  (lat_addr),
        .fill_data (rom_data),
        .data      (data[i]),
        .ok        (ok[i]),
        .miss      (miss[i])
      );
    end
  endgenerate

  assign char_data = data[CL_CHAR];
  assign scr_data  = data[CL_SCR];
  assign obj_data  = data[CL_OBJ];
  assign char_ok   = ok[CL_CHAR];
  assign scr_ok    = ok[CL_SCR];
  assign obj_ok    = ok[CL_OBJ];

  assign pick = arb_pick(miss, rr_obj);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    rr_nx    = rr_obj;
    lat_nx   = lat_addr;
    req_nx   = rom_req;
    addr_nx  = rom_addr;
    fill     = '0;
    case (state)
      IDLE: if (|miss) begin
        gnt_nx   = pick;
        lat_nx   = addr[pick];
        addr_nx  = off[pick] + AW'(addr[pick]);
        req_nx   = 1'b1;
        state_nx = REQ;
        if (pick == CL_SCR)      rr_nx = 1'b1;
        else if (pick == CL_OBJ) rr_nx = 1'b0;
      end
      REQ: if (rom_ack) begin
        req_nx = 1'b0;
        // ack and dst together collapse the WAIT state into this cycle
        if (rom_dst) begin
          fill[gnt] = 1'b1;
          state_nx  = IDLE;
        end else begin
          state_nx  = WAIT;
        end
      end
      WAIT: if (rom_dst) begin
        fill[gnt] = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= CL_CHAR;
      rr_obj   <= 1'b0;
      lat_addr <= '0;
      rom_req  <= 1'b0;
      rom_addr <= '0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      rr_obj   <= rr_nx;
      lat_addr <= lat_nx;
      rom_req  <= req_nx;
      rom_addr <= addr_nx;
    end
  end

`ifdef JTDD_ARB_STATS_EN
  logic [NCL-1:0][15:0] stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall <= '0;
    end else begin
      for (int i = 0; i < NCL; i++)
        if (miss[i] && stall[i] != 16'hFFFF) stall[i] <= stall[i] + 16'd1;
    end
  end

  assign stall_cnt = stall;
`endif
endmodule

// File: tb/tb_jtdd_gfxrom_arb.sv
// Directed bench for jtdd_gfxrom_arb: expected ROM addresses are queued when a
// miss is set up and popped when the arbiter raises rom_req.
`timescale 1ns/1ps
module tb_jtdd_gfxrom_arb;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        char_cs = 0, scr_cs = 0, obj_cs = 0;
  logic [17:0] char_addr = 0, scr_addr = 0, obj_addr = 0;
  logic [7:0]  char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic        rom_req, rom_ack = 0, rom_dst = 0;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data = 0;
`ifdef JTDD_ARB_STATS_EN
  logic [47:0] stall_cnt;
`endif

  jtdd_gfxrom_arb dut (
    .clk(clk), .rst_n(rst_n),
    .char_cs(char_cs), .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_dst(rom_dst),
    .rom_data(rom_data)
`ifdef JTDD_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [19:0] sbq[$];
  logic [19:0] cur_a;

  function automatic logic [7:0] rom_f(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ 8'h87;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output logic [19:0] e);
    int n;
    n = 0;
    while (rom_req !== 1'b1 && n < 50) begin tick(); n++; end
    chk("req_seen", 32'(rom_req), 32'd1);
    e = (sbq.size() > 0) ? sbq.pop_front() : 20'hxxxxx;
    chk("rom_addr", 32'(rom_addr), 32'(e));
    cur_a = rom_addr;
  endtask

  task automatic serve_ack(input int ack_dly, input logic with_dst);
    logic [19:0] e;
    wait_req(e);
    repeat (ack_dly) begin
      tick();
      chk("req_hold", 32'(rom_req), 32'd1);
      chk("addr_hold", 32'(rom_addr), 32'(e));
    end
    rom_ack = 1'b1;
    if (with_dst) begin rom_dst = 1'b1; rom_data = rom_f(cur_a); end
    tick();
    rom_ack = 1'b0; rom_dst = 1'b0;
    chk("req_drop", 32'(rom_req), 32'd0);
  endtask

  task automatic serve_dst(input int dst_dly);
    repeat (dst_dly - 1) tick();
    rom_dst = 1'b1; rom_data = rom_f(cur_a);
    tick();
    rom_dst = 1'b0;
  endtask

  task automatic serve(input int a, input int d);
    serve_ack(a, 1'b0);
    serve_dst(d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] e;
    // reset state
    repeat (3) tick();
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
    chk("rst_data", {8'd0, char_data, scr_data, obj_data}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: char miss, fill, then same-cycle ok drop on address change
    char_cs = 1; char_addr = 18'h00123; #1;
    chk("t1_miss_ok", 32'(char_ok), 32'd0);
    sbq.push_back(20'h00123);
    serve(2, 4);
    chk("t1_ok", 32'(char_ok), 32'd1);
    chk("t1_data", 32'(char_data), 32'hA5);
    char_addr = 18'h00124; #1;
    chk("t1_ok_drop", 32'(char_ok), 32'd0);
    sbq.push_back(20'h00124);
    serve(1, 1);
    chk("t1_ok2", 32'(char_ok), 32'd1);
    chk("t1_data2", 32'(char_data), 32'(rom_f(20'h00124)));
    char_cs = 0;

    // 2: scroll/object round robin
    scr_cs = 1; scr_addr = 18'h00010; obj_cs = 1; obj_addr = 18'h00020;
    sbq.push_back(20'h10010); sbq.push_back(20'h40020);
    serve(1, 2);
    chk("t2_scr_ok", 32'(scr_ok), 32'd1);
    chk("t2_scr_data", 32'(scr_data), 32'(rom_f(20'h10010)));
    serve(0, 1);
    chk("t2_obj_ok", 32'(obj_ok), 32'd1);
    chk("t2_obj_data", 32'(obj_data), 32'(rom_f(20'h40020)));
    scr_addr = 18'h00011;
    sbq.push_back(20'h10011);
    serve(1, 1);
    scr_addr = 18'h00012; obj_addr = 18'h00021;
    sbq.push_back(20'h40021); sbq.push_back(20'h10012);
    serve_ack(1, 1'b1);
    chk("t2_same_cyc_ok", 32'(obj_ok), 32'd1);
    chk("t2_same_cyc_data", 32'(obj_data), 32'(rom_f(20'h40021)));
    serve(1, 1);
    chk("t2_scr_ok2", 32'(scr_ok), 32'd1);

    // 3: all three miss, char first and not starved
    char_cs = 1; char_addr = 18'h3FFFF; scr_addr = 18'h00013; obj_addr = 18'h00022;
    sbq.push_back(20'h3FFFF); sbq.push_back(20'h40022);
    serve(1, 1);
    chk("t3_char_ok", 32'(char_ok), 32'd1);
    chk("t3_char_data", 32'(char_data), 32'(rom_f(20'h3FFFF)));
    serve(1, 1);
    chk("t3_obj_ok", 32'(obj_ok), 32'd1);
    char_addr = 18'h00200; #1;
    chk("t3_char_drop", 32'(char_ok), 32'd0);
    sbq.push_back(20'h00200); sbq.push_back(20'h10013);
    serve(1, 1);
    chk("t3_char_ok2", 32'(char_ok), 32'd1);
    serve(1, 1);
    chk("t3_scr_ok", 32'(scr_ok), 32'd1);
    chk("t3_scr_data", 32'(scr_data), 32'(rom_f(20'h10013)));

    // 4: address change in WAIT, then cs drop in flight
    char_addr = 18'h00300;
    sbq.push_back(20'h00300);
    serve_ack(1, 1'b0);
    char_addr = 18'h00301;
    serve_dst(2);
    chk("t4_stale_ok", 32'(char_ok), 32'd0);
    sbq.push_back(20'h00301);
    serve(1, 1);
    chk("t4_ok", 32'(char_ok), 32'd1);
    chk("t4_data", 32'(char_data), 32'(rom_f(20'h00301)));
    obj_addr = 18'h00030;
    sbq.push_back(20'h40030);
    serve_ack(0, 1'b0);
    obj_cs = 0;
    serve_dst(1);
    chk("t4_cs_gate", 32'(obj_ok), 32'd0);
    obj_cs = 1; #1;
    chk("t4_cs_hit", 32'(obj_ok), 32'd1);
    chk("t4_cs_data", 32'(obj_data), 32'(rom_f(20'h40030)));

    // 5: async reset with rom_req high, late dst ignored
    scr_addr = 18'h00014;
    sbq.push_back(20'h10014);
    wait_req(e);
    rst_n = 1'b0; #1;
    chk("t5_req", 32'(rom_req), 32'd0);
    chk("t5_addr", 32'(rom_addr), 32'd0);
    chk("t5_ok", {29'd0, char_ok, scr_ok, obj_ok}, 32'd0);
    chk("t5_data", {8'd0, char_data, scr_data, obj_data}, 32'd0);
    char_cs = 0; scr_cs = 0; obj_cs = 0;
    tick();
    rst_n = 1'b1;
    tick();
    rom_dst = 1'b1; rom_data = 8'h5A;
    tick();
    rom_dst = 1'b0;
    scr_cs = 1; #1;
    chk("t5_late_dst", 32'(scr_ok), 32'd0);
    chk("t5_idle_req", 32'(rom_req), 32'd0);
    sbq.push_back(20'h10014);
    serve(1, 1);
    chk("t5_refill_ok", 32'(scr_ok), 32'd1);
    chk("t5_refill_data", 32'(scr_data), 32'(rom_f(20'h10014)));

`ifdef JTDD_ARB_STATS_EN
    // 6: scroll stall counter saturates
    scr_addr = 18'h00015;
    sbq.push_back(20'h10015);
    wait_req(e);
    repeat (70000) tick();
    chk("t6_stall_sat", 32'(stall_cnt[31:16]), 32'hFFFF);
    chk("t6_still_req", 32'(rom_req), 32'd1);
    rst_n = 1'b0; #1;
    chk("t6_stall_rst", 32'(stall_cnt), 32'd0);
    rst_n = 1'b1;
`endif

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
